nand_id_probe: RTL

Host-side command sequencer that sits directly upstream of nand_master and drives its command interface (activate/cmd_in/data_in, observing busy/data_out). On a single start pulse it runs the power-up identification sequence: chip enable, READ ID at a configurable address, then ID_LEN MI_GET_ID_BYTE fetches. The fetched bytes are captured into a packed register for the system controller. A watchdog aborts the sequence if the master stalls.

---
 rtl/nand_id_probe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nand_id_probe.sv
// nand_id_probe: power-up READ ID sequencer driving the nand_master command port.
// Optional feature macro: NAND_ID_PROBE_CHECK_EN adds the id_match output and its comparator.
`ifndef MI_CHIP_ENABLE
`define MI_CHIP_ENABLE 8'h09
`endif
`ifndef M_NAND_READ_ID
`define M_NAND_READ_ID 8'h03
`endif
`ifndef MI_GET_ID_BYTE
`define MI_GET_ID_BYTE 8'h0E
`endif

module nand_id_probe #(
    parameter int                  ID_LEN          = 5,
    parameter logic [7:0]          ID_ADDR         = 8'h00,
    parameter logic [7:0]          CMD_CHIP_ENABLE = `MI_CHIP_ENABLE,
    parameter logic [7:0]          CMD_READ_ID     = `M_NAND_READ_ID,
    parameter logic [7:0]          CMD_GET_ID_BYTE = `MI_GET_ID_BYTE,
`ifdef NAND_ID_PROBE_CHECK_EN
    parameter logic [8*ID_LEN-1:0] EXPECTED_ID     = 40'h86_03_FF_E5_2C,
`endif
    parameter int                  TIMEOUT_CYCLES  = 4096
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                start,
    output logic                ready,
    output logic                done,
    output logic                error,
    output logic [8*ID_LEN-1:0] id_data,
`ifdef NAND_ID_PROBE_CHECK_EN
    output logic                id_match,
`endif
    output logic                m_activate,
    output logic [7:0]          m_cmd,
    output logic [7:0]          m_data_in,
    input  logic [7:0]          m_data_out,
    input  logic                m_busy
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_IDLE = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;
    localparam int            CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    STEP_LAST = 4'(ID_LEN + 1);

    logic [2:0]          r_state;
    logic [3:0]          r_step;
    logic [CW-1:0]       r_cnt;
    logic                r_error;
    logic [8*ID_LEN-1:0] r_id;
    logic [7:0]          r_cmd;
    logic [7:0]          r_data;
    logic [3:0]          w_step_nx;
`ifdef NAND_ID_PROBE_CHECK_EN
    logic                r_match;
    assign id_match = r_match;
`endif

    assign w_step_nx  = r_step + 4'd1;
    assign ready      = (r_state == S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign error      = r_error;
    assign id_data    = r_id;
    assign m_cmd      = r_cmd;
    assign m_data_in  = r_data;
    // activate only in the ISSUE cycle once the master is idle, so it can never repeat back-to-back
    assign m_activate = (r_state == S_ISSUE) && !m_busy;

    // sequencer: command/data registers load on entry to ISSUE and hold until the next ISSUE
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_step  <= 4'd0;
            r_cnt   <= '0;
            r_error <= 1'b0;
            r_id    <= '0;
            r_cmd   <= 8'd0;
            r_data  <= 8'd0;
`ifdef NAND_ID_PROBE_CHECK_EN
            r_match <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_ISSUE;
                    r_step  <= 4'd0;
                    r_error <= 1'b0;
                    r_id    <= '0;
                    r_cmd   <= CMD_CHIP_ENABLE;
                    r_data  <= 8'd0;
`ifdef NAND_ID_PROBE_CHECK_EN
                    r_match <= 1'b0;
`endif
                end
                S_ISSUE: if (!m_busy) r_state <= S_WAIT_ACK;
                S_WAIT_ACK: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (!m_busy) r_state <= (r_step >= 4'd2) ? S_CAPTURE : S_NEXT;
                    else if (r_cnt == CNT_LAST) begin
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    for (int k = 0; k < ID_LEN; k++)
                        if (r_step == 4'(k + 2)) r_id[8*k +: 8] <= m_data_out;
                    r_state <= S_NEXT;
                end
                S_NEXT: if (r_step == STEP_LAST) begin
                    r_state <= S_FINISH;
`ifdef NAND_ID_PROBE_CHECK_EN
                    r_match <= (r_id == EXPECTED_ID);
`endif
                end else begin
                    r_step  <= w_step_nx;
                    r_cmd   <= (w_step_nx == 4'd1) ? CMD_READ_ID : CMD_GET_ID_BYTE;
                    r_data  <= (w_step_nx == 4'd1) ? ID_ADDR : 8'd0;
                    r_state <= S_ISSUE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
